// File: rtl/serdesphy_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : serdesphy_rx_framer
// Brief    : Serial RX framer. Hunts for SYNC_WORD, verifies alignment over
//            LOCK_CNT frames, then emits MSB-first data nibbles while locked.
//            Define SERDESPHY_PRBS_CHK_EN to build the PRBS7 payload checker.
// Revision : 1.0 - initial release
// ============================================================================
module serdesphy_rx_framer #(
    parameter logic [7:0] SYNC_WORD    = 8'hD2,
    parameter int         DATA_NIBBLES = 4,
    parameter int         LOCK_CNT     = 3,
    parameter int         LOSS_CNT     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       cdr_lock,
    input  logic       prbs_en,
    input  logic       err_clr,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       frame_lock,
    output logic       prbs_err,
    output logic [7:0] err_cnt
);

    localparam int c_frame_bits = 8 + 4 * DATA_NIBBLES;
    localparam int c_cnt_w      = $clog2(c_frame_bits);
    localparam int c_hit_w      = $clog2(LOCK_CNT + 1);
    localparam int c_miss_w     = $clog2(LOSS_CNT + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0]  c_data_last = c_cnt_w'(4 * DATA_NIBBLES);
    localparam logic [c_hit_w-1:0]  c_hit_last  = c_hit_w'(LOCK_CNT - 1);
    localparam logic [c_miss_w-1:0] c_miss_last = c_miss_w'(LOSS_CNT - 1);

    localparam logic [1:0] c_st_hunt   = 2'd0;
    localparam logic [1:0] c_st_verify = 2'd1;
    localparam logic [1:0] c_st_locked = 2'd2;

    logic [7:0]          r_sr;
    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [c_hit_w-1:0]  r_hit_cnt;
    logic [c_miss_w-1:0] r_miss_cnt;
    logic                r_emit_en;
    logic [3:0]          r_rx_data;
    logic                r_rx_valid;
    logic                r_frame_lock;

    logic [7:0]          w_sr_next;
    logic                w_sync;
    logic                w_wrap;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic                w_data_pos;
    logic                w_data_bit;
    logic                w_nib_done;
    logic                w_unused;

    // bit_cnt == 0 marks the last sync bit; data occupies counts 1..4*DATA_NIBBLES
    assign w_sr_next  = {r_sr[6:0], bit_in};
    assign w_sync     = (w_sr_next == SYNC_WORD);
    assign w_wrap     = (r_bit_cnt == c_cnt_last);
    assign w_cnt_next = w_wrap ? '0 : r_bit_cnt + c_cnt_w'(1);
    assign w_data_pos = (w_cnt_next != '0) && (w_cnt_next <= c_data_last);
    assign w_data_bit = bit_valid && cdr_lock && (r_state == c_st_locked) && r_emit_en && w_data_pos;
    assign w_nib_done = w_data_bit && (w_cnt_next[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr         <= 8'h00;
            r_state      <= c_st_hunt;
            r_bit_cnt    <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_emit_en    <= 1'b0;
            r_rx_data    <= 4'h0;
            r_rx_valid   <= 1'b0;
            r_frame_lock <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (!cdr_lock) begin
                if (bit_valid) r_sr <= w_sr_next;
                r_state      <= c_st_hunt;
                r_hit_cnt    <= '0;
                r_miss_cnt   <= '0;
                r_emit_en    <= 1'b0;
                r_frame_lock <= 1'b0;
            end else if (bit_valid) begin
                r_sr <= w_sr_next;
                case (r_state)
                    c_st_hunt: begin
                        if (w_sync) begin
                            r_bit_cnt <= '0;
                            r_hit_cnt <= c_hit_w'(1);
                            r_state   <= c_st_verify;
                        end
                    end
                    c_st_verify: begin
                        r_bit_cnt <= w_cnt_next;
                        if (w_wrap) begin
                            if (!w_sync) begin
                                r_hit_cnt <= '0;
                                r_state   <= c_st_hunt;
                            end else if (r_hit_cnt == c_hit_last) begin
                                r_hit_cnt    <= '0;
                                r_miss_cnt   <= '0;
                                r_emit_en    <= 1'b0;
                                r_frame_lock <= 1'b1;
                                r_state      <= c_st_locked;
                            end else begin
                                r_hit_cnt <= r_hit_cnt + c_hit_w'(1);
                            end
                        end
                    end
                    c_st_locked: begin
                        r_bit_cnt <= w_cnt_next;
                        // Data is held back until the first wrap after lock is declared
                        if (w_wrap) begin
                            if (w_sync) begin
                                r_miss_cnt <= '0;
                                r_emit_en  <= 1'b1;
                            end else if (r_miss_cnt == c_miss_last) begin
                                r_miss_cnt   <= '0;
                                r_emit_en    <= 1'b0;
                                r_frame_lock <= 1'b0;
                                r_state      <= c_st_hunt;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + c_miss_w'(1);
                                r_emit_en  <= 1'b1;
                            end
                        end
                        if (w_nib_done) begin
                            r_rx_data  <= w_sr_next[3:0];
                            r_rx_valid <= 1'b1;
                        end
                    end
                    default: r_state <= c_st_hunt;
                endcase
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_lock = r_frame_lock;

`ifdef SERDESPHY_PRBS_CHK_EN
    logic [6:0] r_lfsr;
    logic [2:0] r_seed_cnt;
    logic       r_nib_err;
    logic       r_prbs_err;
    logic [7:0] r_err_cnt;
    logic       w_bit_err;
    logic       w_nib_err;
    logic       w_err_pulse;

    // Self-synchronising: prediction uses the received bits 6 and 7 back
    assign w_bit_err   = (r_seed_cnt == 3'd7) && (bit_in != (r_lfsr[6] ^ r_lfsr[5]));
    assign w_nib_err   = r_nib_err | w_bit_err;
    assign w_err_pulse = prbs_en && w_nib_done && w_nib_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr     <= 7'h00;
            r_seed_cnt <= 3'd0;
            r_nib_err  <= 1'b0;
            r_prbs_err <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            r_prbs_err <= w_err_pulse;
            if (!prbs_en || !cdr_lock || (r_state != c_st_locked)) begin
                r_seed_cnt <= 3'd0;
                r_nib_err  <= 1'b0;
            end else if (w_data_bit) begin
                r_lfsr    <= {r_lfsr[5:0], bit_in};
                r_nib_err <= w_nib_done ? 1'b0 : w_nib_err;
                if (r_seed_cnt != 3'd7) r_seed_cnt <= r_seed_cnt + 3'd1;
            end
            if (err_clr) r_err_cnt <= 8'h00;
            else if (w_err_pulse && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign prbs_err = r_prbs_err;
    assign err_cnt  = r_err_cnt;
    assign w_unused = r_sr[7];
`else
    assign prbs_err = 1'b0;
    assign err_cnt  = 8'h00;
    assign w_unused = r_sr[7] ^ prbs_en ^ err_clr;
`endif

endmodule
`default_nettype wire

// File: doc/serdesphy_rx_framer.md
SERDESPHY_RX_FRAMER -- requirements
Module: serdesphy_rx_framer

Interface
REQ-001 Parameter SYNC_WORD, default 8'hD2, frame alignment pattern, MSB received first.
REQ-002 Parameter DATA_NIBBLES, default 4, data nibbles per frame; frame length F = 8 + 4*DATA_NIBBLES bits (default 24).
REQ-003 Parameter LOCK_CNT, default 3, consecutive on-position sync hits needed to declare lock.
REQ-004 Parameter LOSS_CNT, default 4, consecutive on-position sync misses needed to drop lock.
REQ-005 Ports, in this order:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- bit_in  in  1  recovered serial bit from the CDR.
- bit_valid  in  1  qualifies bit_in; one pulse per recovered bit.
- cdr_lock  in  1  CDR lock indicator.
- prbs_en  in  1  enables the PRBS7 check on data nibbles.
- err_clr  in  1  clears err_cnt.
- rx_data  out  4  received data nibble, first-received bit in bit 3.
- rx_valid  out  1  one-cycle strobe qualifying rx_data.
- frame_lock  out  1  high in the LOCKED state.
- prbs_err  out  1  one-cycle strobe, nibble failed the PRBS7 check.
- err_cnt  out  8  saturating count of errored nibbles.

Function
REQ-006 On each bit_valid cycle an 8-bit shift register shall update as sr <= {sr[6:0], bit_in}; when bit_valid is low, no state, counter or output register shall change, except rx_valid and prbs_err clearing and the actions in REQ-011 and REQ-015.
REQ-007 The FSM shall have three states:
- HUNT: on the first bit_valid cycle where the updated sr equals SYNC_WORD, load bit_cnt = 0 and hit_cnt = 1, then go to VERIFY.
- VERIFY: bit_cnt counts modulo F. At the wrap, a sync match increments hit_cnt, and reaching LOCK_CNT moves to LOCKED. A sync miss returns to HUNT.
- LOCKED: bit_cnt keeps counting modulo F, and data is emitted per REQ-009.
REQ-008 In LOCKED, at each wrap position a sync miss shall increment miss_cnt, and a hit shall clear it; miss_cnt reaching LOSS_CNT shall move to HUNT.
REQ-009 In LOCKED, bits 8..F-1 of each frame shall be collected MSB-first into nibbles. rx_valid shall go high for exactly one cycle, in the cycle after the bit_valid that completes the nibble. rx_data shall hold its value until the next strobe.
REQ-010 Sync bits shall never be emitted as data. A SYNC_WORD match at any non-wrap position shall be ignored in VERIFY and LOCKED.
REQ-011 If cdr_lock is low, the FSM shall enter HUNT on that cycle regardless of bit_valid. A partial nibble shall be discarded with no rx_valid, and hit_cnt and miss_cnt shall be cleared.
REQ-012 The frames in which lock is declared or lost shall emit no data; output starts with the frame following the LOCKED transition.
REQ-013 frame_lock shall be high exactly while the state is LOCKED.

PRBS check (compiled in only, see REQ-017)
REQ-014 PRBS7 uses x^7+x^6+1 and is self-synchronising:
- predicted bit = lfsr[6]^lfsr[5]; each received data bit shifts into lfsr.
- The first 7 data bits after entering LOCKED, or after prbs_en rises, seed lfsr and flag no errors.
- After seeding, a nibble with one or more mismatches shall pulse prbs_err coincident with its rx_valid.
- prbs_en low shall suppress prbs_err and reseed.
REQ-015 err_cnt shall increment on each prbs_err pulse and saturate at 255. err_clr shall set it to 0 and take priority over a simultaneous increment.

Reset
REQ-016 While rst is high at a clk edge, the following shall be cleared:
- state = HUNT;
- sr, bit_cnt, hit_cnt, miss_cnt and lfsr = 0;
- rx_data = 4'h0, rx_valid = 0, frame_lock = 0, prbs_err = 0, err_cnt = 8'h00.
Reset mid-frame discards all partial data.

Configuration
REQ-017 Macro SERDESPHY_PRBS_CHK_EN:
- Defined: REQ-014 and REQ-015 are implemented.
- Undefined: no LFSR or counter logic is present; prbs_err and err_cnt are constant 0; prbs_en and err_clr are ignored.
- Framing behaviour is identical in both builds.

Verification
REQ-018 Send 3 frames of sync 8'hD2 plus data 16'h1234 with cdr_lock=1 -> frame_lock rises at the third sync wrap; frame 4 data 16'h5678 -> rx_valid pulses with 5,6,7,8, one cycle after each 4th bit.
REQ-019 In LOCKED, corrupt sync to 8'hD3 in 3 consecutive frames and then send a correct sync -> lock is held and miss_cnt returns to 0; 4 consecutive corrupt syncs -> frame_lock falls at the 4th wrap.
REQ-020 Drop cdr_lock after 2 bits of a nibble -> HUNT in the same cycle, no rx_valid, frame_lock=0.
REQ-021 Data 8'hD2 embedded mid-frame in LOCKED -> no realignment, nibbles D,2 emitted normally.
REQ-022 (SERDESPHY_PRBS_CHK_EN) PRBS7 payload with prbs_en=1 and one bit flipped after seeding -> prbs_err pulses on the affected nibbles and err_cnt=1 or more; hold err_clr with an error in the same cycle -> err_cnt=0.
REQ-023 Assert rst mid-frame in LOCKED -> all outputs are at their reset values on the next cycle; relock requires LOCK_CNT new syncs.
